// File: rtl/rgb565_grayscale_multi_ise_if.sv
// rgb565_grayscale_multi_ise_if
//   Custom-instruction bus between the CPU and the grayscale unit.
//   master: CPU side (drives start/iseId/valueA/valueB, receives done/result)
//   slave : instruction unit side
//   start  - one-cycle request strobe
//   iseId  - custom instruction number of the current request
//   valueA - first operand word
//   valueB - second operand word
//   done   - one-cycle completion pulse
//   result - result word, zero whenever done is low
interface rgb565_grayscale_multi_ise_if;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (output start, iseId, valueA, valueB, input done, result);
  modport slave  (input start, iseId, valueA, valueB, output done, result);
endinterface

// File: rtl/rgb565_grayscale_multi_ise.sv
// rgb565_grayscale_multi_ise
//   Clocked RGB565 -> 8-bit luma custom instruction. The convert opcode turns
//   four packed pixels into four gray bytes, LANES pixels per clock. The
//   config opcode (customInstructionId+1) reprograms the R/G/B weights and
//   returns the previous weights.
//   Optional macro RGB565_GRAY_SATURATE_EN: clamp luma at 255 instead of
//   wrapping to the low 8 bits.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - custom-instruction bus (slave modport)
module rgb565_grayscale_multi_ise #(
  parameter logic [7:0] customInstructionId = 8'd13,
  parameter int         LANES               = 1,
  parameter logic [7:0] DEFAULT_RW          = 8'd77,
  parameter logic [7:0] DEFAULT_GW          = 8'd150,
  parameter logic [7:0] DEFAULT_BW          = 8'd29
) (
  input logic                          clock,
  input logic                          reset,
  rgb565_grayscale_multi_ise_if.slave  bus
);

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("rgb565_grayscale_multi_ise: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  localparam logic [7:0] CONFIG_ID = customInstructionId + 8'd1;
  // Lane-0 pixel index of the final CONVERT cycle.
  localparam logic [1:0] LAST_IDX  = 2'(4 - LANES);
  localparam logic [1:0] IDX_STEP  = 2'(LANES);

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [15:0] pix_q [4];
  logic [31:0] hold_q;
  logic [7:0]  rw_q, gw_q, bw_q;

  logic        cvt_hit, cfg_hit;
  logic [7:0]  lane_gray [LANES];
  logic [1:0]  lane_idx  [LANES];

  assign cvt_hit = bus.start && (state == IDLE) && (bus.iseId == customInstructionId);
  assign cfg_hit = bus.start && (state == IDLE) && (bus.iseId == CONFIG_ID);

  // One luma datapath per lane; lane l handles pixel idx+l this cycle.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0]  pix_idx;
    logic [15:0] px;
    logic [7:0]  r8, g8, b8;
    logic [17:0] sum;
    logic [9:0]  quot;
    logic        unused_bits;

    assign pix_idx = idx + 2'(l);
    assign px      = pix_q[pix_idx];
    // Bit replication so that full-scale 5/6-bit channels map to 255.
    assign r8      = {px[15:11], px[15:13]};
    assign g8      = {px[10:5],  px[10:9]};
    assign b8      = {px[4:0],   px[4:2]};
    assign sum     = ({10'd0, r8} * {10'd0, rw_q})
                   + ({10'd0, g8} * {10'd0, gw_q})
                   + ({10'd0, b8} * {10'd0, bw_q});
    assign quot    = sum[17:8];
`ifdef RGB565_GRAY_SATURATE_EN
    assign lane_gray[l] = (quot > 10'd255) ? 8'hFF : quot[7:0];
    assign unused_bits  = ^sum[7:0];
`else
    assign lane_gray[l] = quot[7:0];
    assign unused_bits  = ^{sum[7:0], quot[9:8]};
`endif
    assign lane_idx[l]  = pix_idx;
  end

  // Next-state logic: convert runs 4/LANES cycles, config goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cvt_hit)      state_nxt = CONVERT;
        else if (cfg_hit) state_nxt = DONE;
      end
      CONVERT: if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operands, weights and the result holding register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      hold_q <= '0;
      rw_q   <= DEFAULT_RW;
      gw_q   <= DEFAULT_GW;
      bw_q   <= DEFAULT_BW;
      for (int i = 0; i < 4; i++) pix_q[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cvt_hit) begin
            pix_q[0] <= bus.valueA[15:0];
            pix_q[1] <= bus.valueA[31:16];
            pix_q[2] <= bus.valueB[15:0];
            pix_q[3] <= bus.valueB[31:16];
            idx      <= '0;
          end else if (cfg_hit) begin
            // Old weights are returned; new ones take effect at the same edge.
            hold_q <= {8'd0, bw_q, gw_q, rw_q};
            if (bus.valueA[31]) begin
              rw_q <= DEFAULT_RW;
              gw_q <= DEFAULT_GW;
              bw_q <= DEFAULT_BW;
            end else begin
              rw_q <= bus.valueA[7:0];
              gw_q <= bus.valueA[15:8];
              bw_q <= bus.valueA[23:16];
            end
          end
        end
        CONVERT: begin
          for (int l = 0; l < LANES; l++) begin
            hold_q[{lane_idx[l], 3'b000} +: 8] <= lane_gray[l];
          end
          // Wraps back to 0 after the last step, ready for the next convert.
          idx <= idx + IDX_STEP;
        end
        default: ;
      endcase
    end
  end

  assign bus.done   = (state == DONE);
  assign bus.result = (state == DONE) ? hold_q : '0;

endmodule

// File: tb/tb_rgb565_grayscale_multi_ise.sv
// tb_rgb565_grayscale_multi_ise
//   Directed bench driving LANES=1, 2 and 4 instances with identical commands
//   and checking latency, done pulses and results against hand-computed values.
module tb_rgb565_grayscale_multi_ise;

  localparam logic [7:0] CVT_ID = 8'd13;
  localparam logic [7:0] CFG_ID = 8'd14;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ise_id = 8'd0;
  logic [31:0] value_a = 32'd0;
  logic [31:0] value_b = 32'd0;

  int checks = 0;
  int errors = 0;

  int lanes_of [3] = '{1, 2, 4};
  int done_cnt [3];
  int done_cyc [3];
  int idle_bad [3];
  logic [31:0] done_res [3];

  logic        done_w [3];
  logic [31:0] res_w  [3];

  always #5 clock = ~clock;

  rgb565_grayscale_multi_ise_if bus_l1 ();
  rgb565_grayscale_multi_ise_if bus_l2 ();
  rgb565_grayscale_multi_ise_if bus_l4 ();

  assign bus_l1.start = start;  assign bus_l1.iseId = ise_id;
  assign bus_l1.valueA = value_a; assign bus_l1.valueB = value_b;
  assign bus_l2.start = start;  assign bus_l2.iseId = ise_id;
  assign bus_l2.valueA = value_a; assign bus_l2.valueB = value_b;
  assign bus_l4.start = start;  assign bus_l4.iseId = ise_id;
  assign bus_l4.valueA = value_a; assign bus_l4.valueB = value_b;

  assign done_w[0] = bus_l1.done;  assign res_w[0] = bus_l1.result;
  assign done_w[1] = bus_l2.done;  assign res_w[1] = bus_l2.result;
  assign done_w[2] = bus_l4.done;  assign res_w[2] = bus_l4.result;

  rgb565_grayscale_multi_ise #(.LANES(1)) dut_l1 (.clock(clock), .reset(reset), .bus(bus_l1));
  rgb565_grayscale_multi_ise #(.LANES(2)) dut_l2 (.clock(clock), .reset(reset), .bus(bus_l2));
  rgb565_grayscale_multi_ise #(.LANES(4)) dut_l4 (.clock(clock), .reset(reset), .bus(bus_l4));

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Issue one command in the current cycle (cycle 0), then observe cycles 1..cycles.
  // Operands are scrambled after the start edge to prove they were latched.
  task automatic apply_stimulus(input logic [7:0] ise, input logic [31:0] a, input logic [31:0] b,
                                input int cycles, input int hold_start,
                                input int inject_cyc, input int reset_cyc);
    start = 1'b1; ise_id = ise; value_a = a; value_b = b;
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0; done_cyc[i] = -1; idle_bad[i] = 0; done_res[i] = '0;
    end
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clock);
      start = (k < hold_start);
      if (k == 1 && hold_start <= 1) begin
        value_a = ~a; value_b = ~b;
      end
      if (k == inject_cyc) begin
        start = 1'b1; ise_id = CVT_ID; value_a = 32'h0; value_b = 32'h0;
      end
      reset = (k == reset_cyc);
      for (int i = 0; i < 3; i++) begin
        if (done_w[i]) begin
          done_cnt[i]++;
          if (done_cyc[i] < 0) begin
            done_cyc[i] = k; done_res[i] = res_w[i];
          end
        end else if (res_w[i] != 32'h0) begin
          idle_bad[i]++;
        end
      end
    end
    start = 1'b0; reset = 1'b0;
  endtask

  task automatic check_op(input string tag, input int exp_cfg_cycle, input logic [31:0] exp_res);
    for (int i = 0; i < 3; i++) begin
      int exp_cyc;
      exp_cyc = (exp_cfg_cycle > 0) ? exp_cfg_cycle : 4 / lanes_of[i] + 1;
      check_output($sformatf("%s_cycle_l%0d", tag, lanes_of[i]), 32'(done_cyc[i]), 32'(exp_cyc));
      check_output($sformatf("%s_pulses_l%0d", tag, lanes_of[i]), 32'(done_cnt[i]), 32'd1);
      check_output($sformatf("%s_result_l%0d", tag, lanes_of[i]), done_res[i], exp_res);
      check_output($sformatf("%s_idle0_l%0d", tag, lanes_of[i]), 32'(idle_bad[i]), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] sat_exp;
`ifdef RGB565_GRAY_SATURATE_EN
    sat_exp = 32'hFFFFFFFF;
`else
    sat_exp = 32'hFAFAFAFA;
`endif
    $display("[TB] start");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("reset_done_l%0d", lanes_of[i]), {31'd0, done_w[i]}, 32'd0);
      check_output($sformatf("reset_result_l%0d", lanes_of[i]), res_w[i], 32'd0);
    end

    // Foreign instruction id held for 8 cycles: must be ignored.
    apply_stimulus(8'd47, 32'h0, 32'h0, 8, 8, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("foreign_pulses_l%0d", lanes_of[i]), 32'(done_cnt[i]), 32'd0);
      check_output($sformatf("foreign_idle0_l%0d", lanes_of[i]), 32'(idle_bad[i]), 32'd0);
    end

    // Pure red / green / blue / white with default weights.
    apply_stimulus(CVT_ID, 32'h07E0F800, 32'hFFFF001F, 8, 1, 0, 0);
    check_op("primaries", 0, 32'hFF1C954C);

    // Mid-gray-ish pixels and all-zero pixels.
    apply_stimulus(CVT_ID, 32'h84104208, 32'h00000000, 8, 1, 0, 0);
    check_op("midgray", 0, 32'h00008241);
    apply_stimulus(CVT_ID, 32'h0, 32'h0, 8, 1, 0, 0);
    check_op("black", 0, 32'h00000000);

    // Program all weights to 255; returns the defaults.
    apply_stimulus(CFG_ID, 32'h00FFFFFF, 32'h0, 4, 1, 0, 0);
    check_op("cfg_set", 1, 32'h001D964D);
    apply_stimulus(CVT_ID, 32'hFFFFFFFF, 32'hFFFFFFFF, 8, 1, 0, 0);
    check_op("white_heavy", 0, sat_exp);

    // Restore defaults; returns the 255 weights, then defaults are in use.
    apply_stimulus(CFG_ID, 32'h80000000, 32'h0, 4, 1, 0, 0);
    check_op("cfg_restore", 1, 32'h00FFFFFF);
    apply_stimulus(CVT_ID, 32'h07E0F800, 32'hFFFF001F, 8, 1, 0, 0);
    check_op("after_restore", 0, 32'hFF1C954C);

    // Reprogram, then reset during cycle 2: no completion, defaults come back.
    apply_stimulus(CFG_ID, 32'h00FFFFFF, 32'h0, 4, 1, 0, 0);
    check_op("cfg_again", 1, 32'h001D964D);
    apply_stimulus(CVT_ID, 32'h07E0F800, 32'hFFFF001F, 8, 1, 0, 2);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("abort_pulses_l%0d", lanes_of[i]), 32'(done_cnt[i]), 32'd0);
      check_output($sformatf("abort_idle0_l%0d", lanes_of[i]), 32'(idle_bad[i]), 32'd0);
    end
    apply_stimulus(CVT_ID, 32'h07E0F800, 32'hFFFF001F, 8, 1, 0, 0);
    check_op("post_reset", 0, 32'hFF1C954C);

    // Second start while busy must not disturb the conversion.
    apply_stimulus(CVT_ID, 32'h07E0F800, 32'hFFFF001F, 8, 1, 2, 0);
    check_op("busy_start", 0, 32'hFF1C954C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb565_grayscale_multi_ise.md
Name: rgb565_grayscale_multi_ise

Overview:
Clocked, parametrised successor to the combinational RGB565→grayscale custom instruction on the OpenRISC custom-instruction (CI) port. Converts four packed RGB565 pixels to four 8-bit luma bytes per call. Processes LANES pixels per cycle, so area and latency trade off by parameter. Adds a second CI opcode that programs the R/G/B luma weights at run time.

Parameters:
customInstructionId, 8'd13, CI id of the convert opcode; the config opcode is customInstructionId+1
LANES, 1, pixels converted per clock; legal values 1, 2, 4; any other value is a synthesis error
DEFAULT_RW, 8'd77, reset value of the red weight
DEFAULT_GW, 8'd150, reset value of the green weight
DEFAULT_BW, 8'd29, reset value of the blue weight

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  CI start strobe from the CPU, one cycle wide
iseId  in  8  CI number of the current instruction
valueA  in  32  convert: pixel0=[15:0], pixel1=[31:16]; config: Rw=[7:0], Gw=[15:8], Bw=[23:16], restore-defaults=[31]
valueB  in  32  convert: pixel2=[15:0], pixel3=[31:16]; ignored by config
done  out  1  one-cycle completion pulse
result  out  32  convert: gray0..gray3 in bytes [7:0]..[31:24]; config: previous {8'd0,Bw,Gw,Rw}; 0 whenever done=0

Behaviour:
- Reset: done=0, result=0, FSM=IDLE, lane counter=0, weights=DEFAULT_*. Reset wins over start in the same cycle and aborts an operation in progress with no done pulse.
- Hit rule: a command is accepted on a rising edge only when start=1, FSM=IDLE and iseId equals the convert id or the config id. start with any other iseId is ignored: done stays 0 and no state changes.
- FSM states:
  - IDLE: waits for a hit.
  - CONVERT: entered on a convert hit. Operands are latched at the start edge.
  - DONE: single cycle; done=1 and result is driven. Returns to IDLE on the next edge.
- CONVERT sequencing: each cycle processes pixels idx..idx+LANES-1 and writes the matching result bytes to a holding register. idx advances by LANES. After 4/LANES cycles the FSM enters DONE.
- Latency: the start edge is cycle 0. done is high during cycle 4/LANES+1, so 5 for LANES=1, 3 for LANES=2, 2 for LANES=4.
- Config hit: the old weights are copied to the result register. The weights are then updated at the same edge: to the defaults if valueA[31]=1, otherwise to valueA[23:0]. FSM goes directly to DONE, so done is high in cycle 1.
- A convert issued after a config uses the new weights.
- start asserted in CONVERT or DONE is ignored; the CPU stalls until done, so this only guards against a misbehaving master.
- Arithmetic per pixel:
  - Expand to 8 bits by bit replication: R8={r,r[4:2]}, G8={g,g[5:4]}, B8={b,b[4:2]}, so 31 maps to 255 and 63 maps to 255.
  - sum = R8*Rw + G8*Gw + B8*Bw, computed in 18 bits unsigned without overflow.
  - gray = sum>>8, reduced to 8 bits as set by the optional feature below.
- Weights are the same for all lanes and are stable for the whole of a conversion.

Optional Feature:
- Macro: RGB565_GRAY_SATURATE_EN.
- Defined: gray = (sum>>8) > 255 ? 255 : sum>>8.
- Undefined: gray = (sum>>8)[7:0], which wraps. Default weights (sum of 256) never reach the wrap region, so the macro only matters after reprogramming.

Test Plan:
1. Reset, then start=1, iseId=47, A=B=0 -> done stays 0 and result stays 0 for 8 cycles.
2. Default weights; convert with A=32'h07E0F800, B=32'hFFFF001F -> done=1 exactly in cycle 4/LANES+1, result=32'hFF1C954C. Run for LANES=1, 2 and 4.
3. Convert A=32'h84104208 (pixel0=rgb(8,16,8)) -> result[7:0]=8'h41. Convert A=B=0 -> result=0.
4. Config with A=32'h00FFFFFF -> done in cycle 1, result=32'h001D964D. Then convert with all pixels 16'hFFFF -> result=32'hFFFFFFFF with RGB565_GRAY_SATURATE_EN defined, 32'hFAFAFAFA without. Config with A[31]=1 -> defaults restored and returns 32'h00FFFFFF.
5. Assert reset during cycle 2 of a LANES=1 convert -> no done pulse, result=0. A new convert issued immediately after completes normally with default weights.
6. Pulse start with the convert id again during CONVERT -> ignored, exactly one done pulse, result unchanged from the original operands.
